// File: rtl/seq_det_word_ctrl_pkg.sv
// Shared definitions for the word-level "1001" detector sequencer.
package seq_det_pkg;

    localparam int unsigned WORD_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [3:0] DET_PATTERN = 4'b1001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_det_word_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_det_word_ctrl.sv
// Serialises parallel words LSB-first into an external Mealy "1001" detector
// and returns the per-word hit count plus a saturating running total.
module seq_det_word_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned HIT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              det_in,
    output logic              det_clr,
    input  logic              det_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [HIT_W-1:0]  m_hits,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              busy
);

    localparam int unsigned          IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]     LAST  = IDX_W'(WORD_W - 1);

    state_t             state;
    logic [WORD_W-1:0]  shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [HIT_W-1:0]   hit_acc;
    logic               hit;

    // The detector output is only meaningful while a bit is being driven.
    assign hit = (state == SHIFT) && det_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            hit_acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        shreg   <= s_data;
                        bit_idx <= '0;
                        hit_acc <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + IDX_W'(1);
                    if (hit) begin
                        hit_acc <= hit_acc + HIT_W'(1);
                    end
                    if (bit_idx == LAST) begin
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    if (m_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready = (state == IDLE);
        m_valid = (state == REPORT);
        busy    = (state != IDLE);
        det_clr = (state != SHIFT);
        det_in  = (state == SHIFT) && shreg[0];
        m_hits  = (state == REPORT) ? hit_acc : '0;
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_total (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (clr_cnt),
        .count (total_cnt)
    );

endmodule
